// File: rtl/input_ctrl_pkg.sv
// Shared definitions for the packet input/output controllers: default widths
// and the sequencing state enum.
package input_ctrl_pkg;

  localparam int PORTNUM_DEF        = 16;
  localparam int BLK_ADDR_WIDTH_DEF = 10;
  localparam int LEN_WIDTH_DEF      = 10;
  localparam int TIMES_WIDTH_DEF    = 4;
  localparam int DATA_WIDTH_DEF     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WR   = 2'd2,
    ENQ  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/input_ctrl_blk_wr_cnt.sv
// Word offset within the current block plus the packet word count, with
// block-end / packet-end flags used by the input controller FSM.
module input_ctrl_blk_wr_cnt #(
  parameter int LEN_WIDTH   = 10,
  parameter int TIMES_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pkt_clr,
  input  logic                   blk_clr,
  input  logic                   inc,
  input  logic [LEN_WIDTH-1:0]   len,
  output logic [TIMES_WIDTH-1:0] offset,
  output logic                   blk_last,
  output logic                   pkt_last,
  output logic                   pkt_done
);

  localparam logic [LEN_WIDTH-1:0]   LEN_ONE = 1;
  localparam logic [TIMES_WIDTH-1:0] OFF_ONE = 1;

  logic [LEN_WIDTH-1:0] wcnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      offset <= '0;
      wcnt   <= '0;
    end else begin
      if (pkt_clr)  wcnt <= '0;
      else if (inc) wcnt <= wcnt + LEN_ONE;
      if (blk_clr)  offset <= '0;
      else if (inc) offset <= offset + OFF_ONE;
    end
  end

  // blk_last/pkt_last qualify the word being written now; pkt_done is the
  // state after that word has been counted.
  assign blk_last = (offset == '1);
  assign pkt_last = ((wcnt + LEN_ONE) == len);
  assign pkt_done = (wcnt == len);

endmodule

// File: rtl/input_ctrl.sv
// Packet input controller: takes a header, fetches shared-memory blocks, writes
// payload words into them and enqueues each filled block. Optional INPUT_CTRL_LEN_CHK_EN rejects len==0.
module input_ctrl
  import input_ctrl_pkg::*;
#(
  parameter int PORTNUM        = PORTNUM_DEF,
  parameter int BLK_ADDR_WIDTH = BLK_ADDR_WIDTH_DEF,
  parameter int LEN_WIDTH      = LEN_WIDTH_DEF,
  parameter int TIMES_WIDTH    = TIMES_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [$clog2(PORTNUM)-1:0]          i_port,
  input  logic [LEN_WIDTH-1:0]                i_len,
  input  logic                                i_hdr_vld,
  output logic                                o_hdr_rdy,
  input  logic [DATA_WIDTH-1:0]               i_data,
  input  logic                                i_data_vld,
  output logic                                o_data_rdy,
  output logic                                o_blk_req,
  input  logic [BLK_ADDR_WIDTH-1:0]           i_blk_addr,
  input  logic                                i_blk_addr_vld,
  output logic                                o_wr_en,
  output logic [BLK_ADDR_WIDTH+TIMES_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0]               o_wr_data,
  output logic                                o_enq_vld,
  output logic [$clog2(PORTNUM)-1:0]          o_enq_port,
  output logic [BLK_ADDR_WIDTH-1:0]           o_enq_blk_addr,
  output logic [LEN_WIDTH-1:0]                o_enq_len,
  output logic                                o_enq_first,
  output logic                                o_last_blk_vld,
  output logic [TIMES_WIDTH-1:0]              o_last_w_times,
  output logic                                o_err
);

  localparam int PW = $clog2(PORTNUM);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

  ctrl_state_e              state_q, state_d;
  logic [PW-1:0]            port_q;
  logic [LEN_WIDTH-1:0]     len_q;
  logic [BLK_ADDR_WIDTH-1:0] blk_q;
  logic                     first_q;
  logic                     hdr_acc, grant, wr_hs, len_zero;
  logic [TIMES_WIDTH-1:0]   offset;
  logic                     blk_last, pkt_last, pkt_done;

`ifdef INPUT_CTRL_LEN_CHK_EN
  logic err_q;
  assign len_zero = (i_len == '0);
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) err_q <= 1'b0;
    else          err_q <= hdr_acc && len_zero;
  end
  assign o_err = err_q;
`else
  assign len_zero = 1'b0;
  assign o_err    = 1'b0;
`endif

  input_ctrl_blk_wr_cnt #(
    .LEN_WIDTH  (LEN_WIDTH),
    .TIMES_WIDTH(TIMES_WIDTH)
  ) u_cnt (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .pkt_clr (hdr_acc),
    .blk_clr (grant),
    .inc     (wr_hs),
    .len     (len_q),
    .offset  (offset),
    .blk_last(blk_last),
    .pkt_last(pkt_last),
    .pkt_done(pkt_done)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      port_q  <= '0;
      len_q   <= '0;
      blk_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hdr_acc) begin
        port_q  <= i_port;
        len_q   <= i_len;
        first_q <= 1'b1;
      end
      if (grant) blk_q <= i_blk_addr;
      if (state_q == ENQ) first_q <= 1'b0;
    end
  end

  always_comb begin
    state_d        = state_q;
    hdr_acc        = 1'b0;
    grant          = 1'b0;
    wr_hs          = 1'b0;
    o_hdr_rdy      = 1'b0;
    o_data_rdy     = 1'b0;
    o_blk_req      = 1'b0;
    o_wr_en        = 1'b0;
    o_wr_addr      = '0;
    o_wr_data      = '0;
    o_enq_vld      = 1'b0;
    o_enq_port     = '0;
    o_enq_blk_addr = '0;
    o_enq_len      = '0;
    o_enq_first    = 1'b0;
    o_last_blk_vld = 1'b0;
    o_last_w_times = '0;
    case (state_q)
      IDLE: begin
        o_hdr_rdy = 1'b1;
        if (i_hdr_vld) begin
          hdr_acc = 1'b1;
          if (!len_zero) state_d = REQ;
        end
      end
      REQ: begin
        o_blk_req = 1'b1;
        if (i_blk_addr_vld) begin
          grant   = 1'b1;
          state_d = WR;
        end
      end
      WR: begin
        o_data_rdy = 1'b1;
        if (i_data_vld) begin
          wr_hs     = 1'b1;
          o_wr_en   = 1'b1;
          o_wr_addr = {blk_q, offset};
          o_wr_data = i_data;
          if (blk_last || pkt_last) state_d = ENQ;
        end
      end
      ENQ: begin
        o_enq_vld      = 1'b1;
        o_enq_port     = port_q;
        o_enq_blk_addr = blk_q;
        o_enq_len      = first_q ? len_q : '0;
        o_enq_first    = first_q;
        if (pkt_done) begin
          o_last_blk_vld = 1'b1;
          o_last_w_times = TIMES_WIDTH'(len_q - LEN_ONE);
          state_d        = IDLE;
        end else begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
